// File: rtl/centroid_divider_seq.sv
// centroid_divider_seq
// Time-multiplexed unsigned divider array for the k-means centroid update.
// One shared restoring divider is applied in turn to each enabled channel,
// lowest index first. Every channel gets a registered quotient and a
// divide-by-zero flag.
//
// Ports
//   clk_i        rising-edge clock
//   reset_ni     asynchronous active-low reset
//   ce_i         clock enable; low freezes every register
//   start_i      job request, accepted only in IDLE
//   en_i         channel enable mask, captured with start
//   dividend_i   flattened dividends, channel i at [i*DIVIDEND_W +: DIVIDEND_W]
//   divisor_i    flattened divisors, channel i at [i*DIVISOR_W +: DIVISOR_W]
//   busy_o       job in progress (LOAD/DIV)
//   done_o       one-cycle completion pulse (stretched while ce_i is low)
//   all_ready_o  every quotient is valid; held until the next accepted start
//   q_o          flattened quotients, same packing as dividend_i
//   dz_o         per-channel divide-by-zero flag
//
// state | meaning
// IDLE  | waiting for start; results held
// LOAD  | pick lowest pending channel; zero divisor resolved here
// DIV   | DIVIDEND_W restoring steps on the current channel
// DONE  | done pulse, all_ready set, back to IDLE
module centroid_divider_seq #(
    parameter int CHANNELS   = 16,
    parameter int DIVIDEND_W = 20,
    parameter int DIVISOR_W  = 12
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic                             ce_i,
    input  logic                             start_i,
    input  logic [CHANNELS-1:0]              en_i,
    input  logic [CHANNELS*DIVIDEND_W-1:0]   dividend_i,
    input  logic [CHANNELS*DIVISOR_W-1:0]    divisor_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             all_ready_o,
    output logic [CHANNELS*DIVIDEND_W-1:0]   q_o,
    output logic [CHANNELS-1:0]              dz_o
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

    state_t                           state_q;
    logic                             busy_q, done_q, all_ready_q;
    logic [CHANNELS*DIVIDEND_W-1:0]   q_q;
    logic [CHANNELS-1:0]              dz_q;
    logic [CHANNELS-1:0]              pending_q;
    logic [CHANNELS*DIVIDEND_W-1:0]   dvd_q;
    logic [CHANNELS*DIVISOR_W-1:0]    dvs_q;
    logic [DIVISOR_W:0]               rem_q;
    logic [DIVIDEND_W-1:0]            qsh_q;
    logic [CW-1:0]                    cnt_q;

    logic [CHANNELS-1:0]              cur_oh;
    logic [CHANNELS-1:0]              pending_rest;
    logic [IW-1:0]                    cur_idx;
    logic [DIVIDEND_W-1:0]            cur_dvd;
    logic [DIVISOR_W-1:0]             cur_dvs;
    logic [DIVISOR_W+1:0]             shifted;
    logic [DIVISOR_W+1:0]             trial;
    logic                             q_bit;
    logic [DIVISOR_W:0]               rem_d;
    logic [DIVIDEND_W-1:0]            qsh_d;

    // The current channel is the lowest set bit of pending; it stays pending
    // until its quotient is written, so the same selection serves LOAD and DIV.
    always_comb begin
        cur_oh       = pending_q & (~pending_q + CHANNELS'(1));
        pending_rest = pending_q & ~cur_oh;
        cur_idx      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cur_oh[i]) cur_idx = IW'(i);
        end
        cur_dvd = dvd_q[cur_idx*DIVIDEND_W +: DIVIDEND_W];
        cur_dvs = dvs_q[cur_idx*DIVISOR_W +: DIVISOR_W];
    end

    // Restoring step: a borrow out of the trial subtraction (top bit set)
    // means the divisor did not fit, so the shifted remainder is kept.
    always_comb begin
        shifted = {rem_q, qsh_q[DIVIDEND_W-1]};
        trial   = shifted - {2'b00, cur_dvs};
        q_bit   = ~trial[DIVISOR_W+1];
        rem_d   = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
        qsh_d   = {qsh_q[DIVIDEND_W-2:0], q_bit};
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            all_ready_q <= 1'b0;
            q_q         <= '0;
            dz_q        <= '0;
            pending_q   <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            qsh_q       <= '0;
            cnt_q       <= '0;
        end else if (ce_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        dvd_q     <= dividend_i;
                        dvs_q     <= divisor_i;
                        pending_q <= en_i;
                        q_q       <= '0;
                        dz_q      <= '0;
                        if (en_i == '0) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            all_ready_q <= 1'b1;
                        end else begin
                            state_q     <= S_LOAD;
                            busy_q      <= 1'b1;
                            all_ready_q <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (cur_dvs == '0) begin
                        q_q[cur_idx*DIVIDEND_W +: DIVIDEND_W] <= '1;
                        dz_q[cur_idx] <= 1'b1;
                        pending_q     <= pending_rest;
                        if (pending_rest == '0) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            all_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end else begin
                        rem_q   <= '0;
                        qsh_q   <= cur_dvd;
                        cnt_q   <= CW'(DIVIDEND_W - 1);
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    qsh_q <= qsh_d;
                    if (cnt_q == '0) begin
                        q_q[cur_idx*DIVIDEND_W +: DIVIDEND_W] <= qsh_d;
                        pending_q <= pending_rest;
                        if (pending_rest == '0) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            all_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign all_ready_o = all_ready_q;
    assign q_o         = q_q;
    assign dz_o        = dz_q;

endmodule

// File: doc/centroid_divider_seq.md
# centroid_divider_seq

Parametrised, time-multiplexed divider array for the k-means centroid update stage. It divides up to CHANNELS accumulated pixel-component sums by their member counts using one shared restoring divider, iterating over enabled channels only. Results are held in registered per-channel quotient outputs with a per-channel divide-by-zero flag. A start/busy/done handshake replaces the fixed bank of independent dividers.

## Interface
- CHANNELS, 16: number of dividend/divisor pairs (1..32)
- DIVIDEND_W, 20: dividend and quotient width
- DIVISOR_W, 12: divisor width (must be ≤ DIVIDEND_W)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; low freezes all state, outputs held
- start  in  1  job request; accepted only in IDLE with ce=1
- en  in  CHANNELS  channel enable mask, sampled at start
- dividend  in  CHANNELS*DIVIDEND_W  flattened; channel i at [i*DIVIDEND_W +: DIVIDEND_W]
- divisor  in  CHANNELS*DIVISOR_W  flattened; channel i at [i*DIVISOR_W +: DIVISOR_W]
- busy  out  1  high from cycle after accept until DONE
- done  out  1  one-cycle pulse when job completes
- all_ready  out  1  high from DONE until next accepted start
- q  out  CHANNELS*DIVIDEND_W  registered quotients, same packing as dividend
- dz  out  CHANNELS  divide-by-zero flag per channel

## Operation
- Reset (reset=0, async): state IDLE; busy, done, all_ready, q, dz, pending mask, counters all 0.
- IDLE: on start&ce: capture en, dividend, divisor into internal registers; pending=en; clear q and dz for all channels; all_ready←0. If en==0 go DONE, else LOAD. start while not IDLE ignored.
- LOAD (1 cycle): select lowest-index set bit of pending (cur). If divisor[cur]==0: q[cur]←all ones, dz[cur]←1, clear pending[cur], next LOAD if pending nonzero else DONE. Else rem←0, qsh←dividend[cur], count←0, go DIV.
- DIV (DIVIDEND_W cycles): restoring step per cycle: trial={rem,qsh MSB} − divisor (DIVISOR_W+1-bit rem/trial); if nonnegative rem←trial, shift 1 into qsh, else rem←shifted value, shift 0. On count==DIVIDEND_W−1: write q[cur]←final quotient, clear pending[cur], next LOAD if remaining pending nonzero else DONE.
- DONE (1 cycle): done=1, all_ready←1, busy←0, go IDLE.
- Disabled channels: q=0, dz=0 after every job; consume zero cycles.
- Quotient = floor(dividend/divisor), unsigned; remainder discarded.
- ce=0 in any state: no state, counter, or output register changes; done pulse extends while ce low in DONE.

## Timing
- Start accepted at edge 0; busy=1 from cycle 1 (E>0).
- Job latency (start edge to done high) = 1 + Σ per enabled channel: DIVIDEND_W+1 (nonzero divisor) or 1 (zero divisor), ce held high. E=0: done in cycle 1, busy never asserted.
- q[i] valid from the cycle after its final DIV/LOAD write; all channels guaranteed valid when all_ready=1.
- q, dz, all_ready stable in IDLE until next accepted start.
- start asserted same cycle as done: ignored (state is DONE, not IDLE).
- Reset mid-job: aborts immediately; all outputs 0; new start accepted once reset released.
- Inputs need only be valid in the accept cycle.

## Test plan
- Reset: hold reset=0 mid-job -> busy/done/all_ready/q/dz all 0 asynchronously; after release, IDLE accepts start.
- Single channel: en=0x0001, dividend0=1000, divisor0=7 -> done in cycle 22, q0=142, dz=0, other q=0.
- Sparse mask: en=0x8005, ch0=20'hFFFFF/1, ch2=255/255, ch15=999/1000 -> done at cycle 1+3*21=64; q0=1048575, q2=1, q15=0; q1, q3..q14=0.
- Divide-by-zero: en=0x0003, ch0 divisor=0, ch1=50/5 -> done at cycle 23; q0=20'hFFFFF, dz=0x0001, q1=10.
- ce stall: single-channel job, ce=0 for 5 cycles mid-DIV -> done at cycle 27, quotient unchanged from unstalled run; start during busy ignored.
- Empty mask and back-to-back: en=0 -> done in cycle 1, busy never high, all q=0; second start next IDLE cycle with new data -> previous results cleared, new results correct.
